// File: rtl/led_blink_code_pkg.sv
// Shared types and helpers for the blink-code LED sequencer.
package led_blink_code_pkg;

    // S_IDLE | 1-cycle slot where a pending code is taken and the pulse count restarts
    // S_ON   | LED on for one pulse
    // S_GAP  | LED off between two pulses of the same code
    // S_PAUSE| LED off after the last pulse, or the whole period for code 0
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_GAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_ms_tick.sv
// Millisecond prescaler: one-cycle tick every C_TICK_DIV clocks, restartable by a synchronous clear.
module led_ms_tick #(
    parameter int C_TICK_DIV = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(C_TICK_DIV - 1);

    logic [W-1:0] presc_q;
    logic [W-1:0] presc_d;

    always_comb begin
        presc_d = presc_q + W'(1);
        if (clr || (presc_q == LAST)) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Tick depends only on the register so the FSM can use it to decide the clear.
    assign tick = (presc_q == LAST);

endmodule

// File: rtl/led_blink_code.sv
// Blink-code LED sequencer: shows a status code as N equal pulses followed by a long pause.
module led_blink_code
    import led_blink_code_pkg::*;
#(
    parameter int C_CLK_FREQ   = 125000000,
    parameter int C_CODE_WIDTH = 4,
    parameter int C_PULSE_MS   = 200,
    parameter int C_GAP_MS     = 200,
    parameter int C_PAUSE_MS   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_CODE_WIDTH-1:0] code,
    input  logic                    code_valid,
    output logic                    code_ack,
    output logic [C_CODE_WIDTH-1:0] active_code,
    output logic                    led
);
    localparam int C_TICK_DIV = C_CLK_FREQ / 1000;
    localparam int MS_MAX     = max3(C_PULSE_MS, C_GAP_MS, C_PAUSE_MS);
    localparam int MS_W       = $clog2(MS_MAX + 1);

    localparam logic [MS_W-1:0] PULSE_LAST = MS_W'(C_PULSE_MS - 1);
    localparam logic [MS_W-1:0] GAP_LAST   = MS_W'(C_GAP_MS - 1);
    localparam logic [MS_W-1:0] PAUSE_LAST = MS_W'(C_PAUSE_MS - 1);

    state_t                  state_q, state_d;
    logic [C_CODE_WIDTH-1:0] pend_code_q, pend_code_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [C_CODE_WIDTH-1:0] active_q, active_d;
    logic [C_CODE_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [MS_W-1:0]         ms_cnt_q, ms_cnt_d;
    logic                    led_q, led_d;
    logic                    ack_q, ack_d;

    logic                    tick;
    logic                    clr;
    logic                    take;
    logic                    phase_done;
    logic [MS_W-1:0]         phase_last;
    logic [C_CODE_WIDTH-1:0] eff_code;

    led_ms_tick #(
        .C_TICK_DIV (C_TICK_DIV)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        phase_last = PULSE_LAST;
        case (state_q)
            S_GAP:   phase_last = GAP_LAST;
            S_PAUSE: phase_last = PAUSE_LAST;
            default: phase_last = PULSE_LAST;
        endcase
        phase_done = tick && (ms_cnt_q == phase_last);
    end

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pulse_cnt_d = pulse_cnt_q;
        take        = 1'b0;
        eff_code    = active_q;

        case (state_q)
            S_IDLE: begin
                take = pend_vld_q;
                if (take) begin
                    eff_code = pend_code_q;
                end
                active_d    = eff_code;
                pulse_cnt_d = C_CODE_WIDTH'(1);
                state_d     = (eff_code == '0) ? S_PAUSE : S_ON;
            end
            S_ON: begin
                if (phase_done) begin
                    state_d = (pulse_cnt_q == active_q) ? S_PAUSE : S_GAP;
                end
            end
            S_GAP: begin
                if (phase_done) begin
                    pulse_cnt_d = pulse_cnt_q + C_CODE_WIDTH'(1);
                    state_d     = S_ON;
                end
            end
            S_PAUSE: begin
                if (phase_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe in the take cycle is kept for the next sequence.
        pend_code_d = pend_code_q;
        pend_vld_d  = pend_vld_q;
        if (take) begin
            pend_vld_d = 1'b0;
        end
        if (code_valid) begin
            pend_code_d = code;
            pend_vld_d  = 1'b1;
        end

        clr      = (state_d != state_q);
        ms_cnt_d = ms_cnt_q;
        if (clr) begin
            ms_cnt_d = '0;
        end else if (tick) begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
        end

        led_d = (state_d == S_ON);
        ack_d = (state_d == S_IDLE) && pend_vld_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pend_code_q <= '0;
            pend_vld_q  <= 1'b0;
            active_q    <= '0;
            pulse_cnt_q <= '0;
            ms_cnt_q    <= '0;
            led_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_code_q <= pend_code_d;
            pend_vld_q  <= pend_vld_d;
            active_q    <= active_d;
            pulse_cnt_q <= pulse_cnt_d;
            ms_cnt_q    <= ms_cnt_d;
            led_q       <= led_d;
            ack_q       <= ack_d;
        end
    end

    assign led         = led_q;
    assign code_ack    = ack_q;
    assign active_code = active_q;

endmodule
